// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_pkg : opcodes, operand width and FSM encoding for alu_sequencer|
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package alu_seq_pkg;

    localparam int OPND_W   = 4;
    localparam int OP_W     = 3;
    localparam int SETTLE_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_settle_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_settle_cnt : loadable down-counter with zero flag (settle timer)   |
// | Revision       : 1.0                                                   |
// +----------------------------------------------------------------------+
module alu_settle_cnt
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = SETTLE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] loadValue,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Saturates at zero so a stray decrement can never wrap the timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= loadValue;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_sequencer : drives an external ALU, waits for settle, captures    |
// |                 result. Optional macro ALU_SEQ_CHAIN_EN adds chaining.|
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    input  logic              cmd_cin,
    input  logic [OP_W-1:0]   cmd_op,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic              cmd_chain,
`endif
    output logic [OPND_W-1:0] A,
    output logic [OPND_W-1:0] B,
    output logic              CarryIN,
    output logic [OP_W-1:0]   opCodeA,
    input  logic [OPND_W-1:0] Y,
    input  logic              CarryOUT,
    input  logic              overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OPND_W-1:0] rsp_y,
    output logic              rsp_cout,
    output logic              rsp_ovf,
    output logic [OP_W-1:0]   rsp_op,
    output logic [CNT_W-1:0]  op_count,
    output logic              ovf_seen
);

    localparam logic [SETTLE_W-1:0] c_SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    seq_state_t        r_state;
    seq_state_t        w_nextState;
    logic              w_accept;
    logic              w_capture;
    logic              w_handoff;
    logic              w_cntLoad;
    logic              w_cntDec;
    logic              w_cntZero;
    logic [OPND_W-1:0] w_nextA;
    logic              w_nextCin;

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign rsp_valid = (r_state == ST_HOLD);

    alu_settle_cnt #(
        .WIDTH(SETTLE_W)
    ) u_settleCnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cntLoad),
        .dec      (w_cntDec),
        .loadValue(c_SETTLE_LOAD),
        .zero     (w_cntZero)
    );

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_handoff   = 1'b0;
        w_cntLoad   = 1'b0;
        w_cntDec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_cntLoad   = 1'b1;
                    w_nextState = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_cntZero) begin
                    w_capture   = 1'b1;
                    w_nextState = ST_HOLD;
                end else begin
                    w_cntDec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    w_handoff   = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Chained commands ripple the previous nibble's result and carry into A.
    always_comb begin
        w_nextA   = cmd_a;
        w_nextCin = cmd_cin;
`ifdef ALU_SEQ_CHAIN_EN
        if (cmd_chain) begin
            w_nextA   = rsp_y;
            w_nextCin = rsp_cout;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            A        <= '0;
            B        <= '0;
            CarryIN  <= 1'b0;
            opCodeA  <= '0;
            rsp_y    <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_op   <= '0;
            op_count <= '0;
            ovf_seen <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                A       <= w_nextA;
                B       <= cmd_b;
                CarryIN <= w_nextCin;
                opCodeA <= cmd_op;
            end
            if (w_capture) begin
                rsp_y    <= Y;
                rsp_cout <= CarryOUT;
                rsp_ovf  <= overflow;
                rsp_op   <= opCodeA;
                if (overflow) begin
                    ovf_seen <= 1'b1;
                end
            end
            if (w_handoff) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_sequencer : randomized scoreboard bench with a registered ALU   |
// | Revision         : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_a = '0;
    logic [3:0]       cmd_b = '0;
    logic             cmd_cin = 1'b0;
    logic [2:0]       cmd_op = '0;
    logic             cmd_chain = 1'b0;
    logic [3:0]       A, B, Y;
    logic             CarryIN, CarryOUT, overflow;
    logic [2:0]       opCodeA;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [3:0]       rsp_y;
    logic             rsp_cout, rsp_ovf;
    logic [2:0]       rsp_op;
    logic [CNT_W-1:0] op_count;
    logic             ovf_seen;

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_op(cmd_op),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .A(A), .B(B), .CarryIN(CarryIN), .opCodeA(opCodeA),
        .Y(Y), .CarryOUT(CarryOUT), .overflow(overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_op(rsp_op),
        .op_count(op_count), .ovf_seen(ovf_seen)
    );

    // Team ALU: result only valid one clock after its inputs change.
    function automatic logic [5:0] aluCalc(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
        logic [4:0] s;
        logic [3:0] y;
        logic       c, v;
        s = 5'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
                        y = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (y[3] != a[3]); end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
                        y = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (y[3] != a[3]); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~a;
            3'd6: y = a;
            default: y = b;
        endcase
        return {v, c, y};
    endfunction

    logic [5:0] aluReg;
    always @(posedge clk) aluReg <= aluCalc(opCodeA, A, B, CarryIN);
    assign Y        = aluReg[3:0];
    assign CarryOUT = aluReg[4];
    assign overflow = aluReg[5];

    // Reference: plain integer arithmetic, two's-complement range test for overflow.
    function automatic void refModel(input int op, input int a, input int b, input int cin,
                                     output int y, output int cout, output int ovf);
        int sa, sb, s;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        cout = 0; ovf = 0;
        case (op)
            0: begin s = a + b + cin; y = s % 16; cout = s / 16;
                     s = sa + sb + cin; ovf = (s > 7 || s < -8) ? 1 : 0; end
            1: begin s = a + (15 - b) + cin; y = s % 16; cout = s / 16;
                     s = sa - sb - 1 + cin; ovf = (s > 7 || s < -8) ? 1 : 0; end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: y = 15 - a;
            6: y = a;
            default: y = b;
        endcase
    endfunction

    typedef struct {
        int a, b, cin, op;
        int y, cout, ovf;
        int acc;
    } exp_t;

    exp_t q[$];
    exp_t cur, held;
    int   nChecks = 0, nFails = 0;
    int   negCnt = 0, expCount = 0, expOvf = 0, lastY = 0, lastC = 0;
    int   acceptCount = 0, hsCount = 0;
    bit   inFlight = 0, rspSeen = 0, prevRst = 1;

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_reset", cmd_ready, 0);
            q.delete();
            inFlight = 0; rspSeen = 0; prevRst = 1;
            expCount = 0; expOvf = 0; lastY = 0; lastC = 0;
            hsCount = acceptCount;
        end else begin
            if (prevRst) begin
                chk("rst_A", A, 0);             chk("rst_B", B, 0);
                chk("rst_cin", CarryIN, 0);     chk("rst_op", opCodeA, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp", {rsp_y, rsp_cout, rsp_ovf, rsp_op}, 0);
                chk("rst_count", op_count, 0);  chk("rst_ovf_seen", ovf_seen, 0);
                chk("ready_after_reset", cmd_ready, 1);
            end
            prevRst = 0;
            if (inFlight) begin
                chk("alu_A_stable", A, cur.a);      chk("alu_B_stable", B, cur.b);
                chk("alu_cin_stable", CarryIN, cur.cin);
                chk("alu_op_stable", opCodeA, cur.op);
                chk("ready_busy", cmd_ready, 0);
            end
            if (rsp_valid) begin
                if (!rspSeen) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        held = q.pop_front();
                        chk("latency", negCnt - held.acc, SETTLE + 1);
                        chk("rsp_y", rsp_y, held.y);
                        chk("rsp_cout", rsp_cout, held.cout);
                        chk("rsp_ovf", rsp_ovf, held.ovf);
                        chk("rsp_op", rsp_op, held.op);
                        if (held.ovf != 0) expOvf = 1;
                        lastY = held.y; lastC = held.cout;
                    end
                    rspSeen = 1;
                end else begin
                    chk("hold_y", rsp_y, held.y);
                    chk("hold_flags", {rsp_cout, rsp_ovf}, {held.cout[0], held.ovf[0]});
                    chk("hold_op", rsp_op, held.op);
                end
            end
            chk("op_count", op_count, expCount);
            chk("ovf_seen", ovf_seen, expOvf);
            if (rsp_valid && rsp_ready) begin
                expCount = (expCount + 1) % (1 << CNT_W);
                rspSeen = 0; inFlight = 0; hsCount++;
            end
            if (cmd_valid && cmd_ready) begin
                cur.a = cmd_a; cur.b = cmd_b; cur.cin = cmd_cin; cur.op = cmd_op;
`ifdef ALU_SEQ_CHAIN_EN
                if (cmd_chain) begin cur.a = lastY; cur.cin = lastC; end
`endif
                refModel(cur.op, cur.a, cur.b, cur.cin, cur.y, cur.cout, cur.ovf);
                cur.acc = negCnt;
                q.push_back(cur);
                inFlight = 1; acceptCount++;
            end
            negCnt++;
        end
    end

    task automatic sendCmd(input int op, input int a, input int b, input int cin, input int chain);
        int guard = 0;
        cmd_valid = 1'b1; cmd_op = op[2:0]; cmd_a = a[3:0]; cmd_b = b[3:0];
        cmd_cin = cin[0]; cmd_chain = chain[0];
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin @(negedge clk); guard++; end
        if (guard >= 200) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone();
        int guard = 0;
        while (hsCount != acceptCount && guard < 200) begin @(posedge clk); #1; guard++; end
        if (guard >= 200) chk("handshake_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back zero adds: op_count wraps, no overflow.
        rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sendCmd(OP_ADD, 0, 0, 0, 0);
            waitDone();
        end
        chk("wrap_count", op_count, 0);
        chk("wrap_ovf_seen", ovf_seen, 0);

        sendCmd(OP_ADD, 7, 7, 1, 0);
        waitDone();
        chk("ovf_sticky", ovf_seen, 1);

        // Long backpressure in HOLD.
        rsp_ready = 1'b0;
        sendCmd(OP_ADD, 15, 15, 1, 0);
        repeat (12) @(posedge clk);
        #1 rsp_ready = 1'b1;
        waitDone();

        // Commands offered while busy must be ignored.
        rsp_ready = 1'b0;
        sendCmd(OP_SUB, 9, 3, 1, 0);
        repeat (4) begin
            cmd_valid = 1'b1; cmd_a = 4'($urandom); cmd_b = 4'($urandom);
            cmd_op = 3'($urandom); cmd_cin = 1'($urandom);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        waitDone();

        // Reset mid-SETTLE.
        sendCmd(OP_ADD, 5, 6, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("count_after_rst", op_count, 0);

        for (int i = 0; i < 150; i++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            sendCmd($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 1), $urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            rsp_ready = 1'b1;
            waitDone();
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end

`ifdef ALU_SEQ_CHAIN_EN
        sendCmd(OP_ADD, 15, 1, 0, 0);
        waitDone();
        chk("chain_first_y", rsp_y, 0);
        chk("chain_first_cout", rsp_cout, 1);
        sendCmd(OP_ADD, 9, 0, 0, 1);
        chk("chain_A", A, 0);
        chk("chain_cin", CarryIN, 1);
        waitDone();
        chk("chain_second_y", rsp_y, 1);
`endif

        waitDone();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
